timing_gen: RTL
===============

# timing_gen

Cycle timing generator and interrupt sequencer for the 6502 core; it sits upstream of the random control logic. It produces the T-state strobes (T0..T6), the `_ready` stall qualifier, SYNC, BRK6E and the vector-zeroing controls Z_ADL0..2 that the random logic consumes. Each instruction's end is taken from the decoder (TRES). Pending reset, NMI or IRQ is converted into a forced BRK sequence.

## Interface
- No parameters.
- `PHI0` in 1: single system clock; one PHI0 rising edge = one CPU cycle.
- `RST` in 1: synchronous, active-high reset.
- `RDY` in 1: external ready; low stalls read cycles.
- `TRES` in 1: from the decoder; the current cycle is the instruction's second-to-last, so the next cycle is T0.
- `BRK_INST` in 1: from the decoder; the current instruction is BRK, real or forced.
- `WR_CYCLE` in 1: the current bus cycle is a write (RDY is ignored).
- `IRQ` in 1: level interrupt request, active-high.
- `NMI` in 1: non-maskable request, active-high, rising-edge sensitive.
- `I_FLAG` in 1: processor I flag; 1 masks IRQ.
- `T0`, `T1`, `T2`, `T3`, `T4`, `T5`, `T6` out 1 each: one-hot T-state strobes.
- `SYNC` out 1: opcode fetch cycle (equals T1).
- `_ready` out 1: 1 = the core is stalled this cycle.
- `BRK6E` out 1: T6 of a BRK sequence, not stalled.
- `BRK_FORCE` out 1: the decoder must substitute opcode 0x00 at the next T1 fetch.
- `WR_INH` out 1: suppresses bus writes (reset sequence pushes).
- `Z_ADL0`, `Z_ADL1`, `Z_ADL2` out 1 each: zero ADL bits 0/1/2 during vector fetch.

## Operation
- State register holds exactly one of T0..T6. Outputs T0..T6 are a direct decode of it.
- When `_ready`=1, the state and all pending flags hold.
- Transitions when `_ready`=0:
  - T0 → T1.
  - Tn with TRES=1 (n=1..6) → T0.
  - Tn with TRES=0 → Tn+1 (n=1..5).
  - T6 with TRES=0 → T0 (maximum length is enforced).
- Ready:
  - `_ready` next = ~RDY & ~WR_CYCLE.
  - A write cycle never stalls.
- NMI:
  - A registered previous-NMI feeds an edge detector.
  - A rising edge sets `nmi_pend`. It is cleared on the BRK6E cycle whose vector was NMI.
- Interrupt sample: in a non-stalled T0 cycle, if `nmi_pend` | (IRQ & ~I_FLAG), set BRK_FORCE.
- BRK_FORCE clears in the first non-stalled T2 after the forced fetch.
- Vector select is latched at the non-stalled T4→T5 transition of a BRK_INST sequence. Priority is reset > NMI > IRQ/BRK.
  - An NMI edge arriving before that point hijacks an IRQ/BRK sequence.
- Z_ADL outputs, asserted during T5 and T6 of a BRK_INST sequence:
  - Z_ADL0 always.
  - Z_ADL1 for reset (vector FFFC).
  - Z_ADL2 for NMI (vector FFFA).
  - None set otherwise (IRQ/BRK, FFFE).
- BRK6E = T6 & BRK_INST & ~`_ready`.
- Reset sequence: `reset_pend`=1 forces BRK_FORCE and WR_INH. Both `reset_pend` and WR_INH clear in the cycle after BRK6E.
- IRQ is level-sensitive. A request dropped before the T0 sample is lost.
- Simultaneous NMI and IRQ: NMI is taken, and IRQ remains sampled at the next T0.

## Timing
- Reset values:
  - State = T1, so T1=1, SYNC=1, T0 and T2..T6=0.
  - `_ready`=0, BRK_FORCE=1, WR_INH=1, BRK6E=0, Z_ADL0..2=0.
  - `nmi_pend`=0, previous-NMI=0.
- RST asserted in any cycle, including mid-instruction or while stalled, reaches reset values at the next edge. The state is frozen in T1 while RST is held.
- TRES sampled in cycle n → T0 in n+1 → T1 in n+2, absent stalls. A 2-cycle instruction (TRES during T1) therefore runs T1, T0.
- RDY low in cycle n (read) → `_ready`=1 in n+1. The state held is the state of n+1.
- NMI rising edge in cycle n → `nmi_pend` set in n+1. It is visible to a T0 sample from n+1 onward.
- All outputs are derived from registers, with no combinational path from inputs. The exception is BRK6E, which uses BRK_INST combinationally.

## Structure
- Package `timing_pkg`:
  - `tstate_t` one-hot enum (T0..T6).
  - `vec_t` enum (VEC_RST, VEC_NMI, VEC_IRQ).
  - Z_ADL mask constants per vector.
- Sub-module `int_ctrl` holds:
  - NMI edge detection.
  - `nmi_pend` and `reset_pend`.
  - BRK_FORCE.
  - Vector latch and Z_ADL decode.
- `timing_gen` holds the T-state register and the ready logic.

## Test plan
- Reset: hold RST 3 cycles, then release with TRES pulsed at T6 → states T1..T6, T0, T1 in sequence. WR_INH=1 until the cycle after BRK6E. Z_ADL0=1 and Z_ADL1=1 in T5/T6.
- TRES=1 in T1 and T3 of consecutive instructions → T1,T0,T1,T2,T3,T0,T1. SYNC is high exactly on the T1 cycles.
- RDY=0 for 3 read cycles during T3 → T3 held 3 extra cycles. With WR_CYCLE=1 the same RDY has no effect.
- IRQ=1 with I_FLAG=0 at T0 → BRK_FORCE=1 at the next T1 and Z_ADL0=1 only in T5/T6. With I_FLAG=1 → no BRK_FORCE.
- NMI rising edge at T3 of an IRQ-initiated BRK → Z_ADL2=1 in T5/T6. `nmi_pend` is cleared after BRK6E, and a held NMI level does not retrigger.
- RST asserted at T4 while `_ready`=1 → next cycle has reset values (T1=1, BRK_FORCE=1, `_ready`=0).

Source files
------------

// File: rtl/timing_pkg.sv
// ============================================================================
// Module      : timing_pkg
// Description : Shared types and constants for the 6502 cycle timing generator.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package timing_pkg;

    typedef enum logic [6:0] {
        ST_T0 = 7'b0000001,
        ST_T1 = 7'b0000010,
        ST_T2 = 7'b0000100,
        ST_T3 = 7'b0001000,
        ST_T4 = 7'b0010000,
        ST_T5 = 7'b0100000,
        ST_T6 = 7'b1000000
    } tstate_t;

    typedef enum logic [1:0] {
        VEC_RST = 2'd0,
        VEC_NMI = 2'd1,
        VEC_IRQ = 2'd2
    } vec_t;

    // Bit order is {Z_ADL2, Z_ADL1, Z_ADL0}; bit 0 is set for every vector.
    localparam logic [2:0] c_ZADL_RST = 3'b011;
    localparam logic [2:0] c_ZADL_NMI = 3'b101;
    localparam logic [2:0] c_ZADL_IRQ = 3'b001;

    function automatic logic [2:0] f_zadl_mask(input vec_t vec);
        logic [2:0] mask;
        case (vec)
            VEC_RST: mask = c_ZADL_RST;
            VEC_NMI: mask = c_ZADL_NMI;
            default: mask = c_ZADL_IRQ;
        endcase
        return mask;
    endfunction

endpackage

`default_nettype wire

// File: rtl/timing_gen_int_ctrl.sv
// ============================================================================
// Module      : int_ctrl
// Description : Interrupt sequencer: NMI edge, pending reset/NMI, BRK forcing,
//               vector latch and ADL zeroing controls.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module int_ctrl
    import timing_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_stall,
    input  tstate_t    i_state,
    input  logic       i_tres,
    input  logic       i_brk_inst,
    input  logic       i_irq,
    input  logic       i_nmi,
    input  logic       i_iflag,
    output logic       o_brk_force,
    output logic       o_wr_inh,
    output logic       o_brk6e,
    output logic [2:0] o_z_adl
);

    logic       r_nmi_prev;
    logic       r_nmi_pend;
    logic       r_reset_pend;
    logic       r_brk_force;
    vec_t       r_vec;
    logic [2:0] r_z_adl;

    logic       w_run;
    logic       w_nmi_edge;
    logic       w_brk6e;
    logic       w_vec_latch;
    logic       w_int_req;
    logic       w_z_keep;
    vec_t       w_vec_sel;

    assign w_run       = ~i_stall;
    assign w_nmi_edge  = i_nmi & ~r_nmi_prev;
    assign w_brk6e     = (i_state == ST_T6) & i_brk_inst & w_run;
    assign w_vec_latch = w_run & (i_state == ST_T4) & i_brk_inst & ~i_tres;
    assign w_int_req   = r_reset_pend | r_nmi_pend | (i_irq & ~i_iflag);
    // Z_ADL survives only the T5 -> T6 step of the vector fetch.
    assign w_z_keep    = (i_state == ST_T5) & ~i_tres;

    always_comb begin
        w_vec_sel = VEC_IRQ;
        if (r_reset_pend) begin
            w_vec_sel = VEC_RST;
        end else if (r_nmi_pend) begin
            w_vec_sel = VEC_NMI;
        end
    end

    // The edge detector runs every cycle so an NMI edge during a stall is kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_nmi_prev   <= 1'b0;
            r_nmi_pend   <= 1'b0;
            r_reset_pend <= 1'b1;
            r_brk_force  <= 1'b1;
            r_vec        <= VEC_RST;
            r_z_adl      <= 3'b000;
        end else begin
            r_nmi_prev <= i_nmi;

            if (w_nmi_edge) begin
                r_nmi_pend <= 1'b1;
            end else if (w_brk6e && (r_vec == VEC_NMI)) begin
                r_nmi_pend <= 1'b0;
            end

            if (w_brk6e) begin
                r_reset_pend <= 1'b0;
            end

            if (w_run && (i_state == ST_T0) && w_int_req) begin
                r_brk_force <= 1'b1;
            end else if (w_run && (i_state == ST_T2)) begin
                r_brk_force <= 1'b0;
            end

            if (w_vec_latch) begin
                r_vec   <= w_vec_sel;
                r_z_adl <= f_zadl_mask(w_vec_sel);
            end else if (w_run && !w_z_keep) begin
                r_z_adl <= 3'b000;
            end
        end
    end

    assign o_brk_force = r_brk_force;
    assign o_wr_inh    = r_reset_pend;
    assign o_brk6e     = w_brk6e;
    assign o_z_adl     = r_z_adl;

endmodule

`default_nettype wire

// File: rtl/timing_gen.sv
// ============================================================================
// Module      : timing_gen
// Description : 6502 T-state generator with ready stall and interrupt-to-BRK
//               sequencing for the random control logic.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module timing_gen
    import timing_pkg::*;
(
    input  logic PHI0,
    input  logic RST,
    input  logic RDY,
    input  logic TRES,
    input  logic BRK_INST,
    input  logic WR_CYCLE,
    input  logic IRQ,
    input  logic NMI,
    input  logic I_FLAG,
    output logic T0,
    output logic T1,
    output logic T2,
    output logic T3,
    output logic T4,
    output logic T5,
    output logic T6,
    output logic SYNC,
    output logic _ready,
    output logic BRK6E,
    output logic BRK_FORCE,
    output logic WR_INH,
    output logic Z_ADL0,
    output logic Z_ADL1,
    output logic Z_ADL2
);

    tstate_t    r_state;
    logic       r_stall;
    logic [2:0] w_z_adl;

    always_ff @(posedge PHI0) begin
        if (RST) begin
            r_state <= ST_T1;
            r_stall <= 1'b0;
        end else begin
            r_stall <= ~RDY & ~WR_CYCLE;
            if (!r_stall) begin
                case (r_state)
                    ST_T0:   r_state <= ST_T1;
                    ST_T1:   r_state <= TRES ? ST_T0 : ST_T2;
                    ST_T2:   r_state <= TRES ? ST_T0 : ST_T3;
                    ST_T3:   r_state <= TRES ? ST_T0 : ST_T4;
                    ST_T4:   r_state <= TRES ? ST_T0 : ST_T5;
                    ST_T5:   r_state <= TRES ? ST_T0 : ST_T6;
                    ST_T6:   r_state <= ST_T0;
                    default: r_state <= ST_T1;
                endcase
            end
        end
    end

    int_ctrl u_int_ctrl (
        .clk         (PHI0),
        .rst         (RST),
        .i_stall     (r_stall),
        .i_state     (r_state),
        .i_tres      (TRES),
        .i_brk_inst  (BRK_INST),
        .i_irq       (IRQ),
        .i_nmi       (NMI),
        .i_iflag     (I_FLAG),
        .o_brk_force (BRK_FORCE),
        .o_wr_inh    (WR_INH),
        .o_brk6e     (BRK6E),
        .o_z_adl     (w_z_adl)
    );

    assign T0     = (r_state == ST_T0);
    assign T1     = (r_state == ST_T1);
    assign T2     = (r_state == ST_T2);
    assign T3     = (r_state == ST_T3);
    assign T4     = (r_state == ST_T4);
    assign T5     = (r_state == ST_T5);
    assign T6     = (r_state == ST_T6);
    assign SYNC   = (r_state == ST_T1);
    assign _ready = r_stall;
    assign Z_ADL0 = w_z_adl[0];
    assign Z_ADL1 = w_z_adl[1];
    assign Z_ADL2 = w_z_adl[2];

endmodule

`default_nettype wire
